// File: rtl/cen_scheduler_if.sv
// Bundle of the configuration, pause/step and enable signals of cen_scheduler.
// The master side drives requests; the slave side is the scheduler.
interface cen_scheduler_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] cfg_num;
    logic [WIDTH-1:0] cfg_den;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             pause_req;
    logic             pause_ack;
    logic             step;
    logic             cen;

    modport master (
        output cfg_num, cfg_den, cfg_valid, pause_req, step,
        input  cfg_ready, cfg_err, pause_ack, cen
    );

    modport slave (
        input  cfg_num, cfg_den, cfg_valid, pause_req, step,
        output cfg_ready, cfg_err, pause_ack, cen
    );
endinterface

// File: rtl/cen_scheduler.sv
// Fractional clock-enable scheduler: NUM enables per DEN clk cycles via an
// accumulator, with run-time ratio reload, phase-aligned pause and single-step.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | accumulate every cycle, config accepted
// S_DRAIN  | pause requested, accumulate until the next enable completes
// S_PAUSED | accumulator held, no enables, config accepted
// S_STEP   | accumulate until exactly one enable has been issued
module cen_scheduler #(
    parameter int WIDTH    = 16,
    parameter int NUM_INIT = 1,
    parameter int DEN_INIT = 4
) (
    input logic             clk,
    input logic             rst_n,
    cen_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_PAUSED = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_acc;
    logic             r_cen;
    logic             r_pause_ack;
    logic             r_cfg_err;

    logic [WIDTH:0]   w_sum;
    logic             w_fire;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_cfg_ready;
    logic             w_cfg_hs;
    logic             w_cfg_ok;

    // acc < den and num <= den, so the wrapped WIDTH-bit subtraction is exact
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_num};
    assign w_fire    = (w_sum >= {1'b0, r_den});
    assign w_acc_nxt = w_fire ? (r_acc + r_num - r_den) : w_sum[WIDTH-1:0];

    assign w_cfg_ready = (r_state == S_RUN) || (r_state == S_PAUSED);
    assign w_cfg_hs    = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_ok    = (bus.cfg_num != '0) && (bus.cfg_num <= bus.cfg_den);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (bus.pause_req) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.pause_req) w_next = S_RUN;
                else if (w_fire)    w_next = S_PAUSED;
            end
            S_PAUSED: begin
                // dropping pause_req wins over a simultaneous step
                if (!bus.pause_req) w_next = S_RUN;
                else if (bus.step)  w_next = S_STEP;
            end
            S_STEP: begin
                if (w_fire) w_next = bus.pause_req ? S_PAUSED : S_RUN;
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_num       <= WIDTH'(NUM_INIT);
            r_den       <= WIDTH'(DEN_INIT);
            r_acc       <= '0;
            r_cen       <= 1'b0;
            r_pause_ack <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            // ack rises one cycle after the final enable and drops as soon as we leave
            r_pause_ack <= (r_state == S_PAUSED) && (w_next == S_PAUSED);
            r_cfg_err   <= w_cfg_hs && !w_cfg_ok;
            if (w_cfg_hs && w_cfg_ok) begin
                r_num <= bus.cfg_num;
                r_den <= bus.cfg_den;
                r_acc <= '0;
                r_cen <= 1'b0;
            end else if (r_state != S_PAUSED) begin
                r_acc <= w_acc_nxt;
                r_cen <= w_fire;
            end else begin
                r_cen <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.pause_ack = r_pause_ack;
    assign bus.cen       = r_cen;

endmodule

// File: tb/tb_cen_scheduler.sv
// Directed bench for cen_scheduler: ratio pattern, config handshake,
// pause/resume, single-step and asynchronous reset.
module tb_cen_scheduler;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cnt;
    int   e;

    cen_scheduler_if #(.WIDTH(W)) bus ();

    cen_scheduler #(.WIDTH(W), .NUM_INIT(1), .DEN_INIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input logic [W-1:0] n, input logic [W-1:0] d);
        bus.cfg_num   = n;
        bus.cfg_den   = d;
        bus.cfg_valid = 1'b1;
    endtask

    initial begin
        logic [W-1:0] bad_n [3];
        logic [W-1:0] bad_d [3];
        bad_n[0] = 16'd0; bad_d[0] = 16'd5;
        bad_n[1] = 16'd9; bad_d[1] = 16'd8;
        bad_n[2] = 16'd1; bad_d[2] = 16'd0;

        rst_n         = 1'b0;
        bus.cfg_num   = '0;
        bus.cfg_den   = '0;
        bus.cfg_valid = 1'b0;
        bus.pause_req = 1'b0;
        bus.step      = 1'b0;
        tick();
        tick();
        chk("rst_cen", bus.cen, 0);
        chk("rst_ack", bus.pause_ack, 0);
        chk("rst_err", bus.cfg_err, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        rst_n = 1'b1;

        // default 1/4: enable after every 4th edge
        cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("run14_cen", bus.cen, (i % 4 == 0) ? 1 : 0);
            cnt += int'(bus.cen);
        end
        chk("run14_count", cnt, 25);
        chk("run14_ready", bus.cfg_ready, 1);

        // invalid configs are accepted, flagged and dropped
        e = 100;
        for (int j = 0; j < 3; j++) begin
            cfg_set(bad_n[j], bad_d[j]);
            tick(); e++;
            chk("bad_err_hi", bus.cfg_err, 1);
            chk("bad_cen", bus.cen, (e % 4 == 0) ? 1 : 0);
            bus.cfg_valid = 1'b0;
            tick(); e++;
            chk("bad_err_lo", bus.cfg_err, 0);
            chk("bad_cen", bus.cen, (e % 4 == 0) ? 1 : 0);
        end
        while (e < 114) begin
            tick(); e++;
            chk("bad_spacing", bus.cen, (e % 4 == 0) ? 1 : 0);
        end

        // pause two cycles after an enable (acc=2)
        bus.pause_req = 1'b1;
        tick();
        chk("drain_cen", bus.cen, 0);
        chk("drain_ack", bus.pause_ack, 0);
        chk("drain_ready", bus.cfg_ready, 0);
        tick();
        chk("drain_last_cen", bus.cen, 1);
        chk("drain_last_ack", bus.pause_ack, 0);
        tick();
        chk("paused_cen", bus.cen, 0);
        chk("paused_ack", bus.pause_ack, 1);
        chk("paused_ready", bus.cfg_ready, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_cen", bus.cen, 0);
            chk("hold_ack", bus.pause_ack, 1);
        end
        bus.pause_req = 1'b0;
        tick();
        chk("resume_ack", bus.pause_ack, 0);
        chk("resume_cen", bus.cen, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("resume_wait", bus.cen, 0);
        end
        tick();
        chk("resume_first_cen", bus.cen, 1);

        // pause again from acc=0, then single-step
        bus.pause_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain2_cen", bus.cen, 0);
        end
        tick();
        chk("drain2_last", bus.cen, 1);
        tick();
        chk("paused2_ack", bus.pause_ack, 1);
        bus.step = 1'b1;
        tick();
        chk("step_ack", bus.pause_ack, 0);
        chk("step_cen", bus.cen, 0);
        chk("step_ready", bus.cfg_ready, 0);
        bus.step = 1'b0;
        tick();
        chk("step_w1", bus.cen, 0);
        bus.step = 1'b1;
        tick();
        chk("step_w2", bus.cen, 0);
        chk("step_w2_ack", bus.pause_ack, 0);
        bus.step = 1'b0;
        tick();
        chk("step_w3", bus.cen, 0);
        tick();
        chk("step_cen_issue", bus.cen, 1);
        tick();
        chk("step_back_ack", bus.pause_ack, 1);
        chk("step_back_cen", bus.cen, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("step_no_extra", bus.cen, 0);
            chk("step_still_ack", bus.pause_ack, 1);
        end

        // step together with pause_req drop: plain resume
        bus.step      = 1'b1;
        bus.pause_req = 1'b0;
        tick();
        chk("stepdrop_ack", bus.pause_ack, 0);
        chk("stepdrop_ready", bus.cfg_ready, 1);
        chk("stepdrop_cen", bus.cen, 0);
        bus.step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stepdrop_wait", bus.cen, 0);
        end
        tick();
        chk("stepdrop_first", bus.cen, 1);

        // 3/8 ratio: enables at relative edges 3,6,8 repeating
        cfg_set(16'd3, 16'd8);
        tick();
        chk("cfg38_cen", bus.cen, 0);
        chk("cfg38_err", bus.cfg_err, 0);
        bus.cfg_valid = 1'b0;
        cnt = 0;
        for (int r = 1; r <= 800; r++) begin
            tick();
            chk("run38_cen", bus.cen, (r % 8 == 3 || r % 8 == 6 || r % 8 == 0) ? 1 : 0);
            cnt += int'(bus.cen);
        end
        chk("run38_count", cnt, 300);

        // 5/5 loaded with a simultaneous pause request
        cfg_set(16'd5, 16'd5);
        bus.pause_req = 1'b1;
        tick();
        chk("full_load_cen", bus.cen, 0);
        chk("full_drain_ready", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        tick();
        chk("full_drain_cen", bus.cen, 1);
        tick();
        chk("full_paused_ack", bus.pause_ack, 1);
        chk("full_paused_cen", bus.cen, 0);
        bus.step = 1'b1;
        tick();
        chk("full_step_ack", bus.pause_ack, 0);
        chk("full_step_cen0", bus.cen, 0);
        bus.step = 1'b0;
        tick();
        chk("full_step_cen1", bus.cen, 1);
        chk("full_step_ack1", bus.pause_ack, 0);
        tick();
        chk("full_back_ack", bus.pause_ack, 1);
        chk("full_back_cen", bus.cen, 0);

        // back to 1/4 while paused
        cfg_set(16'd1, 16'd4);
        tick();
        chk("p_cfg_ack", bus.pause_ack, 1);
        chk("p_cfg_err", bus.cfg_err, 0);
        chk("p_cfg_ready", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b0;
        bus.pause_req = 1'b0;
        tick();
        chk("p_cfg_resume_ack", bus.pause_ack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p_cfg_wait", bus.cen, 0);
        end
        tick();
        chk("p_cfg_first", bus.cen, 1);

        // reset while draining with acc=2
        bus.pause_req = 1'b1;
        tick();
        chk("rd_cen1", bus.cen, 0);
        chk("rd_ready1", bus.cfg_ready, 0);
        tick();
        chk("rd_cen2", bus.cen, 0);
        rst_n         = 1'b0;
        bus.pause_req = 1'b0;
        #1;
        chk("rd_async_cen", bus.cen, 0);
        chk("rd_async_ack", bus.pause_ack, 0);
        chk("rd_async_ready", bus.cfg_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rd_after_cen", bus.cen, (i == 4) ? 1 : 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_cen", bus.cen, 0);
        tick();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
